vend_buy_ctrl: RTL
==================

Name: vend_buy_ctrl

Overview:
Parametrised successor to the single-shot buy-product block. It holds per-item stock for NUM_ITEMS slots and accepts buy requests (item code plus count) over a valid/ready handshake. It validates each request against stock, then dispenses units one at a time over a DP/dp_ack handshake. It sits between the keypad/payment front end and the dispenser motor driver.

Parameters:
NUM_ITEMS, 8, number of product slots (≥2)
CODE_W, 3, item code width; NUM_ITEMS ≤ 2**CODE_W
COUNT_W, 4, requested-count width
STOCK_W, 4, per-slot stock counter width
INIT_STOCK, 10, stock loaded into every slot at reset (< 2**STOCK_W)

Ports:
clock  in  1  single system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  buy request valid
req_ready  out  1  block can accept a request
itemCode  in  CODE_W  slot selected, sampled on accept
itemCount  in  COUNT_W  units requested, sampled on accept
DP  out  1  dispense-pulse request for one unit, held until acked
dp_ack  in  1  dispenser finished one unit
done  out  1  one-cycle pulse, request fully dispensed
err  out  1  one-cycle pulse, request rejected
stock_q  out  NUM_ITEMS*STOCK_W  packed current stock, slot 0 in LSBs
busy  out  1  high in any state other than IDLE
restock_valid  in  1  (VEND_RESTOCK_EN only) load stock
restock_code  in  CODE_W  (VEND_RESTOCK_EN only) slot to load
restock_qty  in  STOCK_W  (VEND_RESTOCK_EN only) value to load

Behaviour:
- Reset (async assert, sync release): state=IDLE; DP=0, done=0, err=0, busy=0, req_ready=1; every slot=INIT_STOCK; latched code/remaining=0.
- FSM states: IDLE, CHECK, DISPENSE, WAIT_ACK, DONE, REJECT.
- IDLE: req_ready=1. On req_valid&&req_ready, latch itemCode/itemCount and go to CHECK. req_ready=0 in all other states.
- CHECK (1 cycle): reject if itemCount==0, itemCode≥NUM_ITEMS, or stock[code]<itemCount; then go to REJECT. Otherwise go to DISPENSE.
- REJECT: err=1 for exactly one cycle, stock unchanged, then IDLE.
- DISPENSE: assert DP, go to WAIT_ACK. DP is registered; it rises one cycle after CHECK.
- WAIT_ACK: DP held at 1 until dp_ack=1. On the ack cycle: stock[code]-=1 and remaining-=1, DP drops next cycle. If the new remaining==0, go to DONE; otherwise go to DISPENSE, so each unit has at least one DP-low cycle. A dp_ack seen outside WAIT_ACK is ignored.
- DONE: done=1 for one cycle, then IDLE.
- Minimum latency, accept to done, with ack immediate: 3+2*N cycles for N units.
- Stock never underflows: CHECK guarantees stock≥remaining. No wrap is possible.
- Reset asserted mid-dispense: DP drops immediately (async) and all stock reloads to INIT_STOCK. Partial dispensing is not remembered.
- stock_q is registered and reflects a decrement the cycle after the ack.

Optional Feature:
VEND_RESTOCK_EN:
- Defined: the restock_* ports exist. In IDLE only, restock_valid loads stock[restock_code]=restock_qty, and code≥NUM_ITEMS is ignored. If restock_valid and req_valid&&req_ready occur in the same cycle, restock wins and req_ready is forced 0 that cycle. Restock in non-IDLE states is ignored.
- Undefined: the restock ports are absent, and stock only decreases after reset.

Decomposition:
- Package vend_pkg: FSM state enum (vend_state_e), the default parameter constants, and a function for the stock_q slice index.
- Sub-module vend_stock_bank holds the NUM_ITEMS×STOCK_W register array with reset load, a decrement port and the optional load port, and exports stock_q. The FSM lives in vend_buy_ctrl.

Test Plan:
1. Reset, then request code=0 count=5 with dp_ack returned 1 cycle after each DP rise → 5 DP pulses, done once, stock_q slot0=5, err never high.
2. Request code=3 count=11 (stock 10) → err pulse 2 cycles after accept, no DP, slot3 stays 10. Also count=0 → err.
3. Request code=2 count=2 with dp_ack delayed 7 cycles → DP held high the full 7 cycles, exactly 2 decrements, slot2=8, done.
4. Assert reset_n=0 during the 2nd DP of a count=4 request → DP=0 immediately, all slots=10, req_ready=1 after release.
5. With NUM_ITEMS=6, request code=7 count=1 → err, no state change. Hold req_valid high while busy → no second accept until IDLE.
6. (VEND_RESTOCK_EN) Restock code=1 qty=15 in IDLE, same cycle as req_valid → slot1=15, request accepted the following cycle. Request count=15 → 15 dispenses, slot1=0.

Source files
------------

// File: rtl/vend_pkg.sv
// ============================================================================
// Module   : vend_pkg
// Shared state encoding, default parameters and stock_q slicing helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vend_pkg;

    localparam int c_DEF_NUM_ITEMS  = 8;
    localparam int c_DEF_CODE_W     = 3;
    localparam int c_DEF_COUNT_W    = 4;
    localparam int c_DEF_STOCK_W    = 4;
    localparam int c_DEF_INIT_STOCK = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4,
        ST_REJECT   = 3'd5
    } vend_state_e;

    // LSB position of a slot inside the packed stock vector.
    function automatic int stock_lsb(input int slot, input int stock_w);
        return slot * stock_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vend_stock_bank.sv
// ============================================================================
// Module   : vend_stock_bank
// Per-slot stock registers with reset load, unit decrement and direct load.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = c_DEF_NUM_ITEMS,
    parameter int CODE_W     = c_DEF_CODE_W,
    parameter int STOCK_W    = c_DEF_STOCK_W,
    parameter int INIT_STOCK = c_DEF_INIT_STOCK
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          dec_en,
    input  logic [CODE_W-1:0]             dec_code,
    input  logic                          ld_en,
    input  logic [CODE_W-1:0]             ld_code,
    input  logic [STOCK_W-1:0]            ld_qty,
    input  logic [CODE_W-1:0]             rd_code,
    output logic [STOCK_W-1:0]            rd_stock,
    output logic [NUM_ITEMS*STOCK_W-1:0]  stock_q
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_slot
            logic [STOCK_W-1:0] r_stock;

            // Codes outside the slot range match no slot, so loads to them vanish.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_stock <= STOCK_W'(INIT_STOCK);
                end else if (ld_en && (ld_code == CODE_W'(gi))) begin
                    r_stock <= ld_qty;
                end else if (dec_en && (dec_code == CODE_W'(gi))) begin
                    r_stock <= r_stock - STOCK_W'(1);
                end
            end

            assign stock_q[stock_lsb(gi, STOCK_W) +: STOCK_W] = r_stock;
        end
    endgenerate

    always_comb begin
        rd_stock = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (rd_code == CODE_W'(i)) begin
                rd_stock = stock_q[i*STOCK_W +: STOCK_W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vend_buy_ctrl.sv
// ============================================================================
// Module   : vend_buy_ctrl
// Buy-request FSM: validates item/count against stock, dispenses unit by unit.
// Optional restock port enabled by macro VEND_RESTOCK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vend_buy_ctrl
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = c_DEF_NUM_ITEMS,
    parameter int CODE_W     = c_DEF_CODE_W,
    parameter int COUNT_W    = c_DEF_COUNT_W,
    parameter int STOCK_W    = c_DEF_STOCK_W,
    parameter int INIT_STOCK = c_DEF_INIT_STOCK
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [CODE_W-1:0]             itemCode,
    input  logic [COUNT_W-1:0]            itemCount,
    output logic                          DP,
    input  logic                          dp_ack,
    output logic                          done,
    output logic                          err,
    output logic [NUM_ITEMS*STOCK_W-1:0]  stock_q,
    output logic                          busy
`ifdef VEND_RESTOCK_EN
    ,
    input  logic                          restock_valid,
    input  logic [CODE_W-1:0]             restock_code,
    input  logic [STOCK_W-1:0]            restock_qty
`endif
);

    localparam logic [2:0] c_S_IDLE     = ST_IDLE;
    localparam logic [2:0] c_S_CHECK    = ST_CHECK;
    localparam logic [2:0] c_S_DISPENSE = ST_DISPENSE;
    localparam logic [2:0] c_S_WAIT_ACK = ST_WAIT_ACK;
    localparam logic [2:0] c_S_DONE     = ST_DONE;
    localparam logic [2:0] c_S_REJECT   = ST_REJECT;

    localparam int c_CMP_W = (COUNT_W > STOCK_W) ? COUNT_W : STOCK_W;

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [CODE_W-1:0]   r_code;
    logic [COUNT_W-1:0]  r_remaining;
    logic                r_dp;

    logic                w_restock;
    logic [CODE_W-1:0]   w_ld_code;
    logic [STOCK_W-1:0]  w_ld_qty;
    logic                w_accept;
    logic                w_ack;
    logic                w_reject;
    logic [STOCK_W-1:0]  w_stock_sel;

`ifdef VEND_RESTOCK_EN
    assign w_restock = restock_valid && (r_state == c_S_IDLE);
    assign w_ld_code = restock_code;
    assign w_ld_qty  = restock_qty;
`else
    assign w_restock = 1'b0;
    assign w_ld_code = '0;
    assign w_ld_qty  = '0;
`endif

    // A restock in IDLE takes the cycle; the request waits one cycle.
    assign req_ready = (r_state == c_S_IDLE) && !w_restock;
    assign w_accept  = req_valid && req_ready;
    assign w_ack     = (r_state == c_S_WAIT_ACK) && dp_ack;

    assign w_reject = (r_remaining == '0)
                   || (int'(r_code) >= NUM_ITEMS)
                   || (c_CMP_W'(w_stock_sel) < c_CMP_W'(r_remaining));

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE:     if (w_accept) w_next = c_S_CHECK;
            c_S_CHECK:    w_next = w_reject ? c_S_REJECT : c_S_DISPENSE;
            c_S_DISPENSE: w_next = c_S_WAIT_ACK;
            c_S_WAIT_ACK: begin
                if (dp_ack) begin
                    w_next = (r_remaining == COUNT_W'(1)) ? c_S_DONE : c_S_DISPENSE;
                end
            end
            c_S_DONE:     w_next = c_S_IDLE;
            c_S_REJECT:   w_next = c_S_IDLE;
            default:      w_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_S_IDLE;
            r_code      <= '0;
            r_remaining <= '0;
            r_dp        <= 1'b0;
        end else begin
            r_state <= w_next;
            // DP is high exactly while in WAIT_ACK, so DISPENSE is always a DP-low gap.
            r_dp    <= (w_next == c_S_WAIT_ACK);
            if (w_accept) begin
                r_code      <= itemCode;
                r_remaining <= itemCount;
            end else if (w_ack) begin
                r_remaining <= r_remaining - COUNT_W'(1);
            end
        end
    end

    assign DP   = r_dp;
    assign done = (r_state == c_S_DONE);
    assign err  = (r_state == c_S_REJECT);
    assign busy = (r_state != c_S_IDLE);

    vend_stock_bank #(
        .NUM_ITEMS  (NUM_ITEMS),
        .CODE_W     (CODE_W),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clock    (clock),
        .reset_n  (reset_n),
        .dec_en   (w_ack),
        .dec_code (r_code),
        .ld_en    (w_restock),
        .ld_code  (w_ld_code),
        .ld_qty   (w_ld_qty),
        .rd_code  (r_code),
        .rd_stock (w_stock_sel),
        .stock_q  (stock_q)
    );

endmodule

`default_nettype wire
